// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int REG_AW_DEF = 5;
  // Architectural zero register; writes to it never create a dependency.
  localparam int REG_ZERO   = 0;

  // Per-stage pipeline-register control: load enable and bubble insert.
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, taken branch and
// data-memory wait, plus a timeout watchdog and stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, br_take, load_use;
  logic              stall_inc, flush_inc;
  stage_ctrl_t       pc_c, if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

  assign mem_wait = mem_req & ~mem_ready;
  assign br_take  = ex_branch_taken & ex_valid;
  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != REG_AW'(REG_ZERO)) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Next state and stage controls; rst overrides everything so the pipe stays empty.
  always_comb begin
    state_nxt = state;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    pc_c      = '{en: 1'b1, flush: 1'b0};
    if_id_c   = '{en: 1'b1, flush: 1'b0};
    id_ex_c   = '{en: 1'b1, flush: 1'b0};
    ex_mem_c  = '{en: 1'b1, flush: 1'b0};
    mem_wb_c  = '{en: 1'b1, flush: 1'b0};
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          pc_c.en        = 1'b0;
          if_id_c.en     = 1'b0;
          id_ex_c.en     = 1'b0;
          ex_mem_c.en    = 1'b0;
          mem_wb_c.flush = 1'b1;
          if (state == RUN)                               state_nxt = MEM_WAIT;
          else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) state_nxt = ERR;
        end else begin
          state_nxt = RUN;
          // A branch held in the frozen EX is acted on here, so it is counted once.
          if (br_take) begin
            if_id_c.flush = 1'b1;
            id_ex_c.flush = 1'b1;
            flush_inc     = 1'b1;
          end else if (load_use) begin
            pc_c.en       = 1'b0;
            if_id_c.en    = 1'b0;
            id_ex_c.flush = 1'b1;
          end
        end
        stall_inc = ~pc_c.en;
      end
      default: begin
        pc_c.en     = 1'b0;
        if_id_c.en  = 1'b0;
        id_ex_c.en  = 1'b0;
        ex_mem_c.en = 1'b0;
      end
    endcase
    if (rst) begin
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      pc_c      = '{en: 1'b0, flush: 1'b0};
      if_id_c   = '{en: 1'b0, flush: 1'b1};
      id_ex_c   = '{en: 1'b0, flush: 1'b1};
      ex_mem_c  = '{en: 1'b0, flush: 1'b0};
      mem_wb_c  = '{en: 1'b0, flush: 1'b1};
    end
  end

  assign pc_en        = pc_c.en;
  assign if_id_en     = if_id_c.en;
  assign if_id_flush  = if_id_c.flush;
  assign id_ex_en     = id_ex_c.en;
  assign id_ex_flush  = id_ex_c.flush;
  assign ex_mem_en    = ex_mem_c.en;
  assign mem_wb_flush = mem_wb_c.flush;
  assign mem_err      = (state == ERR) & ~rst;

  // Fields with no matching port.
  logic unused_bits;
  assign unused_bits = ^{pc_c.flush, ex_mem_c.flush, mem_wb_c.en};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Wait counter: cleared entering MEM_WAIT, counts each stalled MEM_WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wait_cnt <= '0;
    else if (state == RUN && state_nxt == MEM_WAIT) wait_cnt <= '0;
    else if (state == MEM_WAIT && mem_wait)   wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_inc), .clear(1'b0), .cnt(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_inc), .clear(1'b0), .cnt(flush_cnt)
  );

endmodule
